// File: rtl/pool_out_buffer_pkg.sv
// Shared definitions for the pooled-feature-map ping-pong output buffer.
// Holds the map geometry, the RAM address width and the per-bank state encoding.
package pool_out_buffer_pkg;

  localparam int unsigned IMG    = 14;
  localparam int unsigned PAD    = 1;
  localparam int unsigned OUT    = (IMG + 2 * PAD) / 2 - 1;
  localparam int unsigned DEPTH  = OUT * OUT;
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL,
    DRAIN
  } bank_state_e;

endpackage

// File: rtl/pob_bank_ram.sv
// One bank of the output buffer: DEPTH x DATA_W, one write port and one synchronous read port.
// Ports:
//   clk_i    clock
//   we_i     write strobe, waddr_i/wdata_i
//   re_i     read strobe; rdata_o updates one cycle later and holds while re_i is low
//   raddr_i  read address
//   rdata_o  registered read data
// Contents are not reset.
module pob_bank_ram
  import pool_out_buffer_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pool_out_buffer.sv
// Ping-pong buffer for pooled feature maps. The pooling datapath fills one bank while the
// other bank drains, in address order, over a valid/ready stream.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   wr_en, wr_addr, wr_data       one pooled sample per strobe into the write bank
//   frame_done                    commit the write bank and switch to the other one
//   wr_ready                      write bank can accept samples
//   out_data/out_valid/out_ready  drained samples, out_last marks the final one of a frame
//   ovf_err, addr_err             sticky error flags, cleared only by rst
module pool_out_buffer
  import pool_out_buffer_pkg::*;
#(
  parameter bit RELU = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [15:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              frame_done,
  output logic              wr_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              ovf_err,
  output logic              addr_err
);

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic        wbank_q, wbank_d, rbank_q, rbank_d;
  // Issue side runs ahead of the output register; it may start on the next bank before the
  // current one has fully left through out_*.
  logic        ibank_q, ibank_d, idone_q, idone_d;
  logic [AW-1:0] iptr_q, iptr_d;
  logic        ram_vld_q, ram_vld_d, ram_last_q, ram_last_d, ram_bank_q, ram_bank_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic        ovf_q, ovf_d, addr_err_q, addr_err_d;

  logic              wr_open, addr_ok, wr_accept;
  logic [DATA_W-1:0] wdata;
  logic              handshake, drain_end, move, issue, issue_bank, issue_src_ok;
  logic [AW-1:0]     issue_addr;
  logic [DATA_W-1:0] ram_rdata [2];

  assign wr_open   = (state_q[wbank_q] == EMPTY) || (state_q[wbank_q] == FILL);
  assign addr_ok   = wr_addr < 16'(DEPTH);
  assign wr_accept = wr_en && addr_ok && wr_open;
  assign wdata     = (RELU && wr_data[DATA_W-1]) ? '0 : wr_data;

  assign handshake  = out_valid_q && out_ready;
  assign drain_end  = handshake && out_last_q;
  // Fetched word moves to the output register whenever that register is free or emptying.
  assign move       = ram_vld_q && (!out_valid_q || out_ready);
  assign issue_bank = idone_q ? ~ibank_q : ibank_q;
  assign issue_addr = idone_q ? '0 : iptr_q;
  assign issue_src_ok = idone_q ? (state_q[~ibank_q] == FULL)
                                : (state_q[ibank_q] inside {FULL, DRAIN});
  assign issue      = issue_src_ok && (!ram_vld_q || move);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pob_bank_ram u_ram (
      .clk_i   (clk),
      .we_i    (wr_accept && (wbank_q == 1'(b))),
      .waddr_i (wr_addr[AW-1:0]),
      .wdata_i (wdata),
      .re_i    (issue && (issue_bank == 1'(b))),
      .raddr_i (issue_addr),
      .rdata_o (ram_rdata[b])
    );
  end

  always_comb begin
    state_d     = state_q;
    wbank_d     = wbank_q;
    rbank_d     = rbank_q;
    ibank_d     = ibank_q;
    idone_d     = idone_q;
    iptr_d      = iptr_q;
    ram_vld_d   = ram_vld_q;
    ram_last_d  = ram_last_q;
    ram_bank_d  = ram_bank_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ovf_d       = ovf_q;
    addr_err_d  = addr_err_q;

    if (wr_en && !addr_ok) addr_err_d = 1'b1;
    if ((wr_en || frame_done) && !wr_open) ovf_d = 1'b1;

    // The four bank transitions act on banks in distinct states, so they never collide.
    if (wr_accept && (state_q[wbank_q] == EMPTY)) state_d[wbank_q] = FILL;
    if (frame_done && wr_open) begin
      state_d[wbank_q] = FULL;
      wbank_d          = ~wbank_q;
    end
    if (issue && (state_q[issue_bank] == FULL)) state_d[issue_bank] = DRAIN;
    if (drain_end) begin
      state_d[rbank_q] = EMPTY;
      rbank_d          = ~rbank_q;
    end

    if (issue) begin
      ibank_d    = issue_bank;
      iptr_d     = issue_addr + AW'(1);
      idone_d    = (issue_addr == AW'(DEPTH - 1));
      ram_vld_d  = 1'b1;
      ram_last_d = (issue_addr == AW'(DEPTH - 1));
      ram_bank_d = issue_bank;
    end else if (move) begin
      ram_vld_d = 1'b0;
    end

    if (move) begin
      out_data_d  = ram_rdata[ram_bank_q];
      out_valid_d = 1'b1;
      out_last_d  = ram_last_q;
    end else if (handshake) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      ibank_q     <= 1'b0;
      idone_q     <= 1'b0;
      iptr_q      <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      ram_bank_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ovf_q       <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      ibank_q     <= ibank_d;
      idone_q     <= idone_d;
      iptr_q      <= iptr_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      ram_bank_q  <= ram_bank_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ovf_q       <= ovf_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign wr_ready  = wr_open;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign ovf_err   = ovf_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_pool_out_buffer.sv
// Directed bench for pool_out_buffer; a RELU=1 and a RELU=0 instance share all inputs.
module tb_pool_out_buffer;

  logic        clk = 1'b0;
  logic        rst, wr_en, frame_done, out_ready;
  logic [15:0] wr_addr, wr_data;
  logic        wr_ready, out_valid, out_last, ovf_err, addr_err;
  logic [15:0] out_data;
  logic        wr_ready0, out_valid0, out_last0, ovf_err0, addr_err0;
  logic [15:0] out_data0;

  int passed = 0;
  int total  = 0;
  logic [15:0] cap_d  [128];
  logic        cap_l  [128];
  logic [15:0] cap0_d [128];
  int          ncap;

  always #5 clk = ~clk;

  pool_out_buffer #(.RELU(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .wr_ready(wr_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .ovf_err(ovf_err), .addr_err(addr_err)
  );

  pool_out_buffer #(.RELU(1'b0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .wr_ready(wr_ready0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .ovf_err(ovf_err0), .addr_err(addr_err0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; frame_done = 1'b0; out_ready = 1'b0;
    wr_addr = '0; wr_data = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic write_sample(input logic [15:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic write_frame(input logic [15:0] off);
    for (int i = 0; i < 49; i++) write_sample(16'(i), 16'(i) + off);
  endtask

  task automatic commit();
    frame_done = 1'b1;
    step();
    frame_done = 1'b0;
  endtask

  // Gathers n beats from both instances; ncap < n means the budget ran out.
  task automatic collect(input int n, input int budget);
    int cyc = 0;
    ncap = 0;
    out_ready = 1'b1;
    while (ncap < n && cyc < budget) begin
      if (out_valid) begin
        cap_d[ncap] = out_data; cap_l[ncap] = out_last; cap0_d[ncap] = out_data0;
        ncap++;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", out_last); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL rst_data: got %h want 0000", out_data); else passed++;
    total++; if (ovf_err !== 1'b0) $display("FAIL rst_ovf: got %b want 0", ovf_err); else passed++;
    total++; if (addr_err !== 1'b0) $display("FAIL rst_addr_err: got %b want 0", addr_err); else passed++;
    total++; if (wr_ready !== 1'b1) $display("FAIL rst_wr_ready: got %b want 1", wr_ready); else passed++;
  endtask

  task automatic test_single_frame();
    write_frame(16'd1);
    frame_done = 1'b1; out_ready = 1'b1;
    step();
    frame_done = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL t1_lat1: got %b want 0", out_valid); else passed++;
    step();
    total++; if (out_valid !== 1'b0) $display("FAIL t1_lat2: got %b want 0", out_valid); else passed++;
    step();
    for (int i = 0; i < 49; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== 16'(i + 1) || out_last !== (i == 48))
        $display("FAIL t1_beat%0d: valid=%b data=%h last=%b want 1 %h %b",
                 i, out_valid, out_data, out_last, 16'(i + 1), (i == 48));
      else passed++;
      step();
    end
    total++; if (out_valid !== 1'b0) $display("FAIL t1_end_valid: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_relu();
    write_frame(16'd1);
    write_sample(16'd5, 16'hFFF0);
    commit();
    collect(49, 200);
    total++; if (ncap !== 49) $display("FAIL t2_count: got %0d want 49", ncap); else passed++;
    total++; if (cap_d[5] !== 16'h0000) $display("FAIL t2_relu1: got %h want 0000", cap_d[5]); else passed++;
    total++; if (cap0_d[5] !== 16'hFFF0) $display("FAIL t2_relu0: got %h want fff0", cap0_d[5]); else passed++;
    total++; if (cap_d[6] !== 16'd7) $display("FAIL t2_beat6: got %h want 0007", cap_d[6]); else passed++;
    total++; if (cap0_d[4] !== 16'd5) $display("FAIL t2_r0_beat4: got %h want 0005", cap0_d[4]); else passed++;
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    write_frame(16'd1);
    commit();
    step(); step();
    total++; if (wr_ready !== 1'b1) $display("FAIL t3_ready_one: got %b want 1", wr_ready); else passed++;
    write_frame(16'h0100);
    commit();
    total++; if (wr_ready !== 1'b0) $display("FAIL t3_ready_full: got %b want 0", wr_ready); else passed++;
    total++; if (ovf_err !== 1'b0) $display("FAIL t3_ovf_pre: got %b want 0", ovf_err); else passed++;
    write_sample(16'd3, 16'hBEEF);
    total++; if (ovf_err !== 1'b1) $display("FAIL t3_ovf_set: got %b want 1", ovf_err); else passed++;
    collect(98, 400);
    total++; if (ncap !== 98) $display("FAIL t3_count: got %0d want 98", ncap); else passed++;
    for (int i = 0; i < 98; i++) begin
      logic [15:0] exp_d;
      exp_d = (i < 49) ? 16'(i + 1) : 16'(i - 49) + 16'h0100;
      total++;
      if (cap_d[i] !== exp_d || cap_l[i] !== (i == 48 || i == 97))
        $display("FAIL t3_beat%0d: data=%h last=%b want %h %b", i, cap_d[i], cap_l[i], exp_d,
                 (i == 48 || i == 97));
      else passed++;
    end
  endtask

  task automatic test_stall();
    int got = 0;
    int cyc = 0;
    logic hold_chk;
    logic [15:0] held;
    out_ready = 1'b0;
    write_frame(16'h0200);
    commit();
    while (got < 49 && cyc < 300) begin
      out_ready = (cyc % 2 == 0);
      if (out_valid && out_ready) begin
        cap_d[got] = out_data; cap_l[got] = out_last; got++;
      end
      hold_chk = out_valid && !out_ready;
      held = out_data;
      step();
      cyc++;
      if (hold_chk) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held)
          $display("FAIL t4_hold: valid=%b data=%h want 1 %h", out_valid, out_data, held);
        else passed++;
      end
    end
    total++; if (got !== 49) $display("FAIL t4_count: got %0d want 49", got); else passed++;
    for (int i = 0; i < 49; i++) begin
      total++;
      if (cap_d[i] !== 16'(i) + 16'h0200 || cap_l[i] !== (i == 48))
        $display("FAIL t4_beat%0d: data=%h last=%b want %h %b", i, cap_d[i], cap_l[i],
                 16'(i) + 16'h0200, (i == 48));
      else passed++;
    end
  endtask

  task automatic test_addr_err_and_reset();
    do_reset();
    write_frame(16'd1);
    write_sample(16'd49, 16'hDEAD);
    total++; if (addr_err !== 1'b1) $display("FAIL t5_addr_err: got %b want 1", addr_err); else passed++;
    write_sample(16'd66, 16'hBEEF);
    total++; if (wr_ready !== 1'b1) $display("FAIL t5_ready: got %b want 1", wr_ready); else passed++;
    commit();
    collect(49, 200);
    total++; if (ncap !== 49) $display("FAIL t5_count: got %0d want 49", ncap); else passed++;
    total++; if (cap_d[2] !== 16'd3) $display("FAIL t5_beat2: got %h want 0003", cap_d[2]); else passed++;
    total++; if (cap_d[48] !== 16'd49) $display("FAIL t5_beat48: got %h want 0031", cap_d[48]); else passed++;
    total++; if (ovf_err !== 1'b0) $display("FAIL t5_ovf: got %b want 0", ovf_err); else passed++;
    // Reset in the middle of a drain.
    write_frame(16'h0010);
    commit();
    out_ready = 1'b1;
    repeat (10) step();
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL t5_rst_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 16'h0) $display("FAIL t5_rst_data: got %h want 0000", out_data); else passed++;
    total++; if (addr_err !== 1'b0) $display("FAIL t5_rst_addr: got %b want 0", addr_err); else passed++;
    step();
    rst = 1'b0;
    step();
    write_frame(16'h5A00);
    commit();
    collect(49, 200);
    total++; if (ncap !== 49) $display("FAIL t5_post_count: got %0d want 49", ncap); else passed++;
    for (int i = 0; i < 49; i++) begin
      total++;
      if (cap_d[i] !== 16'(i) + 16'h5A00 || cap_l[i] !== (i == 48))
        $display("FAIL t5_post%0d: data=%h last=%b want %h %b", i, cap_d[i], cap_l[i],
                 16'(i) + 16'h5A00, (i == 48));
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int cyc = 0;
    out_ready = 1'b0;
    write_frame(16'h0300);
    commit();
    write_frame(16'h0400);
    out_ready = 1'b1;
    while (got < 49 && cyc < 200) begin
      if (out_valid) begin
        cap_d[got] = out_data; cap_l[got] = out_last; got++;
        if (out_last) frame_done = 1'b1;
      end
      step();
      frame_done = 1'b0;
      cyc++;
    end
    total++; if (got !== 49) $display("FAIL t6_a_count: got %0d want 49", got); else passed++;
    for (int i = 0; i < 49; i++) begin
      total++;
      if (cap_d[i] !== 16'(i) + 16'h0300) $display("FAIL t6_a%0d: got %h want %h", i, cap_d[i],
                                                    16'(i) + 16'h0300);
      else passed++;
    end
    collect(49, 200);
    total++; if (ncap !== 49) $display("FAIL t6_b_count: got %0d want 49", ncap); else passed++;
    for (int i = 0; i < 49; i++) begin
      total++;
      if (cap_d[i] !== 16'(i) + 16'h0400 || cap_l[i] !== (i == 48))
        $display("FAIL t6_b%0d: data=%h last=%b want %h %b", i, cap_d[i], cap_l[i],
                 16'(i) + 16'h0400, (i == 48));
      else passed++;
    end
    total++; if (ovf_err !== 1'b0) $display("FAIL t6_ovf: got %b want 0", ovf_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_relu();
    test_overflow();
    test_stall();
    test_addr_err_and_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
